fighter_action_fsm: RTL and testbench
=====================================

// Module: fighter_action_fsm
// PURPOSE
//  Generalised per-player action state machine for the footsies game. Successor to the
//  fixed-timing sprite FSM: frame data, counter width and side (mirroring) are parameters.
//  Adds hit/block stun, frame-tick pacing, attack edge detection and directional-attack latching.
//  Sits between the input conditioner and the sprite/hitbox/collision logic; one instance per player.
// PARAMETERS
//  START_FRAMES      5   attack startup length in frame ticks (>=1)
//  ACTIVE_FRAMES     2   attack active (hitbox live) length in ticks (>=1)
//  RECOVERY_FRAMES   16  attack recovery length in ticks (>=1)
//  HITSTUN_FRAMES    20  stun length after an unblocked hit (>=1)
//  BLOCKSTUN_FRAMES  10  stun length after a blocked hit (>=1)
//  CNT_W             6   frame counter width; must hold max(*_FRAMES)-1
//  MIRROR            0   0: left=back/right=fwd (P1); 1: right=back/left=fwd (P2)
// PORTS
//  clk                      in   1      system clock
//  reset                    in   1      asynchronous, active-high reset
//  frame_tick               in   1      one-cycle pulse per game frame; all state activity gated by it
//  left                     in   1      left held (level)
//  right                    in   1      right held (level)
//  attack                   in   1      attack button (level; rising edge detected internally)
//  hit_in                   in   1      opponent hitbox overlaps this player's hurtbox (sampled on tick)
//  state                    out  3      0 IDLE,1 BACK,2 FWD,3 ATK_START,4 ATK_ACTIVE,5 ATK_REC,6 BLOCKSTUN,7 HITSTUN
//  frame_count              out  CNT_W  ticks elapsed in current state
//  move_flag                out  1      state is BACK or FWD
//  attack_flag              out  1      state is ATK_START or ATK_ACTIVE
//  hitbox_active            out  1      state is ATK_ACTIVE
//  directional_attack_flag  out  1      current attack sequence began from BACK/FWD (valid states 3-5)
//  stun_flag                out  1      state is BLOCKSTUN or HITSTUN
//  actionable               out  1      state is IDLE, BACK or FWD
// BEHAVIOUR
//  - Reset (async, any time incl. mid-attack/stun): state=IDLE, frame_count=0, dir latch=0,
//    attack history=0; hence all flags 0 except actionable=1. Release takes effect on next clk edge.
//  - State, counter, dir latch, attack history update only on clk edges with frame_tick=1;
//    otherwise hold. Flags are combinational decodes of registered state (0-cycle latency).
//  - back = MIRROR ? right&~left : left&~right; fwd = MIRROR ? left&~right : right&~left.
//  - atk_edge = attack & ~attack_q; attack_q <= attack on every tick.
//  - Priority on a tick, from IDLE/BACK/FWD: (1) hit_in: BACK->BLOCKSTUN, else HITSTUN;
//    (2) atk_edge->ATK_START, dir latch <= (state was BACK|FWD); (3) back->BACK; (4) fwd->FWD;
//    (5) IDLE (both or neither held).
//  - Timed states (3-7): on tick, if frame_count==N-1 advance (START->ACTIVE->REC->IDLE;
//    BLOCKSTUN/HITSTUN->IDLE), else frame_count+1. State occupies exactly N ticks.
//  - hit_in on tick in ATK_START/ATK_ACTIVE/ATK_REC -> HITSTUN (counter-hit); takes priority
//    over timed advance; dir latch cleared.
//  - hit_in during BLOCKSTUN/HITSTUN ignored; counter not restarted.
//  - Every state change (incl. neutral->neutral) loads frame_count=0; staying in BACK/FWD/IDLE
//    increments frame_count, saturating at all-ones.
//  - Attack held through an attack sequence does not re-trigger; must release and re-press.
//  - Exit to IDLE is unconditional; held direction moves to BACK/FWD on the following tick.
//  - Illegal encodings are unreachable; default branch forces IDLE, frame_count=0.
// TESTING
//  1 Defaults, attack press from IDLE, tick every cycle -> START 5 ticks, ACTIVE 2 (hitbox_active=1),
//    REC 16, IDLE at tick 23; directional_attack_flag=0 throughout.
//  2 Hold fwd (MIRROR=0 right) then press attack -> FWD->ATK_START, directional_attack_flag=1
//    through REC; attack held -> no second sequence after IDLE.
//  3 Hold left (MIRROR=0) + hit_in pulse on tick -> BLOCKSTUN 10 ticks, stun_flag=1, then IDLE;
//    MIRROR=1 same stimulus -> HITSTUN 20 ticks.
//  4 hit_in during ATK_START tick 2 -> HITSTUN frame_count=0; hit_in again at stun tick 5 ->
//    ignored, IDLE after 20 ticks total.
//  5 frame_tick every 4th cycle -> no state/counter change between ticks; timings scale x4.
//  6 Assert reset asynchronously mid-ATK_ACTIVE (between edges) -> state=0, frame_count=0,
//    actionable=1 immediately; left+right together -> IDLE.

Source files
------------

// File: rtl/fighter_action_fsm.sv
// Per-player action state machine: movement, attack startup/active/recovery and hit/block stun,
// all paced by a one-cycle frame tick. Frame timings and left/right mirroring are parameters.
module fighter_action_fsm #(
    parameter int START_FRAMES     = 5,
    parameter int ACTIVE_FRAMES    = 2,
    parameter int RECOVERY_FRAMES  = 16,
    parameter int HITSTUN_FRAMES   = 20,
    parameter int BLOCKSTUN_FRAMES = 10,
    parameter int CNT_W            = 6,
    parameter int MIRROR           = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             left,
    input  logic             right,
    input  logic             attack,
    input  logic             hit_in,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] frame_count,
    output logic             move_flag,
    output logic             attack_flag,
    output logic             hitbox_active,
    output logic             directional_attack_flag,
    output logic             stun_flag,
    output logic             actionable
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BACK       = 3'd1,
        ST_FWD        = 3'd2,
        ST_ATK_START  = 3'd3,
        ST_ATK_ACTIVE = 3'd4,
        ST_ATK_REC    = 3'd5,
        ST_BLOCKSTUN  = 3'd6,
        ST_HITSTUN    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_FRAMES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] REC_LAST    = CNT_W'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HIT_LAST    = CNT_W'(HITSTUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLOCK_LAST  = CNT_W'(BLOCKSTUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_reg;
    state_t           neutral_next;
    logic [CNT_W-1:0] count_reg;
    logic             dir_reg;
    logic             attack_q;
    logic             back;
    logic             fwd;
    logic             atk_edge;

    assign back     = (MIRROR != 0) ? (right & ~left) : (left & ~right);
    assign fwd      = (MIRROR != 0) ? (left & ~right) : (right & ~left);
    assign atk_edge = attack & ~attack_q;

    // Neutral target when neither a hit nor a fresh attack press wins; both/neither held -> IDLE
    always_comb begin
        neutral_next = ST_IDLE;
        if (back)
            neutral_next = ST_BACK;
        else if (fwd)
            neutral_next = ST_FWD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            attack_q  <= 1'b0;
        end else if (frame_tick) begin
            attack_q <= attack;
            case (state_reg)
                ST_IDLE, ST_BACK, ST_FWD: begin
                    if (hit_in) begin
                        state_reg <= (state_reg == ST_BACK) ? ST_BLOCKSTUN : ST_HITSTUN;
                        count_reg <= '0;
                    end else if (atk_edge) begin
                        state_reg <= ST_ATK_START;
                        count_reg <= '0;
                        dir_reg   <= (state_reg != ST_IDLE);
                    end else if (neutral_next == state_reg) begin
                        if (count_reg != CNT_MAX)
                            count_reg <= count_reg + CNT_ONE;
                    end else begin
                        state_reg <= neutral_next;
                        count_reg <= '0;
                    end
                end
                ST_ATK_START: begin
                    if (hit_in) begin
                        state_reg <= ST_HITSTUN;
                        count_reg <= '0;
                        dir_reg   <= 1'b0;
                    end else if (count_reg == START_LAST) begin
                        state_reg <= ST_ATK_ACTIVE;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                ST_ATK_ACTIVE: begin
                    if (hit_in) begin
                        state_reg <= ST_HITSTUN;
                        count_reg <= '0;
                        dir_reg   <= 1'b0;
                    end else if (count_reg == ACTIVE_LAST) begin
                        state_reg <= ST_ATK_REC;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                ST_ATK_REC: begin
                    if (hit_in) begin
                        state_reg <= ST_HITSTUN;
                        count_reg <= '0;
                        dir_reg   <= 1'b0;
                    end else if (count_reg == REC_LAST) begin
                        state_reg <= ST_IDLE;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                // Further hits while stunned are ignored so the stun cannot be extended
                ST_BLOCKSTUN: begin
                    if (count_reg == BLOCK_LAST) begin
                        state_reg <= ST_IDLE;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                ST_HITSTUN: begin
                    if (count_reg == HIT_LAST) begin
                        state_reg <= ST_IDLE;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign state                   = state_reg;
    assign frame_count             = count_reg;
    assign move_flag               = (state_reg == ST_BACK) || (state_reg == ST_FWD);
    assign attack_flag             = (state_reg == ST_ATK_START) || (state_reg == ST_ATK_ACTIVE);
    assign hitbox_active           = (state_reg == ST_ATK_ACTIVE);
    assign directional_attack_flag = dir_reg && ((state_reg == ST_ATK_START) ||
                                                 (state_reg == ST_ATK_ACTIVE) ||
                                                 (state_reg == ST_ATK_REC));
    assign stun_flag               = (state_reg == ST_BLOCKSTUN) || (state_reg == ST_HITSTUN);
    assign actionable              = (state_reg == ST_IDLE) || (state_reg == ST_BACK) ||
                                     (state_reg == ST_FWD);

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Scoreboard bench: a P1 instance and a mirrored P2 instance with left/right swapped share one
// expected-response queue; the monitor pops one entry per cycle on the falling edge.
module tb_fighter_action_fsm;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BACK  = 3'd1;
    localparam logic [2:0] S_FWD   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_ACT   = 3'd4;
    localparam logic [2:0] S_REC   = 3'd5;
    localparam logic [2:0] S_BLOCK = 3'd6;
    localparam logic [2:0] S_HIT   = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] cnt;
        logic       dir;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic left_in = 1'b0;
    logic right_in = 1'b0;
    logic attack = 1'b0;
    logic hit_in = 1'b0;

    logic [2:0] state0, state1;
    logic [5:0] fc0, fc1;
    logic mv0, af0, hb0, df0, sf0, ac0;
    logic mv1, af1, hb1, df1, sf1, ac1;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fighter_action_fsm #(.MIRROR(0)) dut_p1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .left(left_in), .right(right_in), .attack(attack), .hit_in(hit_in),
        .state(state0), .frame_count(fc0), .move_flag(mv0), .attack_flag(af0),
        .hitbox_active(hb0), .directional_attack_flag(df0), .stun_flag(sf0), .actionable(ac0)
    );

    // Swapped wiring makes the mirrored instance see the same back/fwd as P1
    fighter_action_fsm #(.MIRROR(1)) dut_p2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .left(right_in), .right(left_in), .attack(attack), .hit_in(hit_in),
        .state(state1), .frame_count(fc1), .move_flag(mv1), .attack_flag(af1),
        .hitbox_active(hb1), .directional_attack_flag(df1), .stun_flag(sf1), .actionable(ac1)
    );

    function automatic logic [14:0] expand(input exp_t e);
        logic mv, af, hb, sf, ac;
        mv = (e.st == S_BACK) || (e.st == S_FWD);
        af = (e.st == S_START) || (e.st == S_ACT);
        hb = (e.st == S_ACT);
        sf = (e.st == S_BLOCK) || (e.st == S_HIT);
        ac = (e.st == S_IDLE) || (e.st == S_BACK) || (e.st == S_FWD);
        return {e.st, e.cnt, mv, af, hb, e.dir, sf, ac};
    endfunction

    // Monitor: one expected entry per clock cycle, compared mid-cycle against both instances
    initial begin
        exp_t        e;
        logic [14:0] want, got0, got1;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e    = sb_q.pop_front();
                want = expand(e);
                got0 = {state0, fc0, mv0, af0, hb0, df0, sf0, ac0};
                got1 = {state1, fc1, mv1, af1, hb1, df1, sf1, ac1};
                vectors++;
                if (got0 !== want) begin
                    miscompares++;
                    $display("FAIL vec%0d p1: got state=%0d count=%0d flags=%b, want state=%0d count=%0d flags=%b",
                             vectors, got0[14:12], got0[11:6], got0[5:0], want[14:12], want[11:6], want[5:0]);
                end
                if (got1 !== want) begin
                    miscompares++;
                    $display("FAIL vec%0d p2_mirror: got state=%0d count=%0d flags=%b, want state=%0d count=%0d flags=%b",
                             vectors, got1[14:12], got1[11:6], got1[5:0], want[14:12], want[11:6], want[5:0]);
                end
            end
        end
    end

    task automatic cyc(input logic t, l, r, a, h, input logic [2:0] st, input int cnt, input logic dir);
        exp_t e;
        frame_tick = t; left_in = l; right_in = r; attack = a; hit_in = h;
        @(posedge clk);
        #1;
        e.st = st; e.cnt = cnt[5:0]; e.dir = dir;
        sb_q.push_back(e);
    endtask

    // n ticked cycles expecting state st with frame_count c0, c0+1, ...
    task automatic run(input int n, input logic l, r, a, h, input logic [2:0] st, input int c0, input logic dir);
        for (int i = 0; i < n; i++)
            cyc(1'b1, l, r, a, h, st, c0 + i, dir);
    endtask

    // Same, but with three untickled cycles after each tick carrying noise that must be ignored
    task automatic run4(input int n, input logic a, input logic [2:0] st, input int c0, input logic dir);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, a, 1'b0, st, c0 + i, dir);
            for (int k = 0; k < 3; k++)
                cyc(1'b0, 1'b1, 1'b0, a, 1'b1, st, c0 + i, dir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, and release without a tick holds everything
        cyc(1'b0, 0, 0, 0, 0, S_IDLE, 0, 0);
        cyc(1'b1, 0, 0, 1, 1, S_IDLE, 0, 0);
        reset = 1'b0;
        cyc(1'b0, 0, 0, 0, 0, S_IDLE, 0, 0);
        run(3, 0, 0, 0, 0, S_IDLE, 1, 0);

        // Neutral attack: 5 + 2 + 16 ticks, then IDLE
        run(5, 0, 0, 1, 0, S_START, 0, 0);
        run(2, 0, 0, 1, 0, S_ACT, 0, 0);
        run(16, 0, 0, 0, 0, S_REC, 0, 0);
        run(2, 0, 0, 0, 0, S_IDLE, 0, 0);

        // Forward attack latches direction; held attack does not retrigger
        run(3, 0, 1, 0, 0, S_FWD, 0, 0);
        run(5, 0, 1, 1, 0, S_START, 0, 1);
        run(2, 0, 1, 1, 0, S_ACT, 0, 1);
        run(16, 0, 1, 1, 0, S_REC, 0, 1);
        cyc(1'b1, 0, 1, 1, 0, S_IDLE, 0, 0);
        run(2, 0, 1, 1, 0, S_FWD, 0, 0);
        cyc(1'b1, 0, 0, 0, 0, S_IDLE, 0, 0);

        // Hit while holding back -> blockstun; hit while holding forward -> hitstun
        run(2, 1, 0, 0, 0, S_BACK, 0, 0);
        cyc(1'b1, 1, 0, 0, 1, S_BLOCK, 0, 0);
        run(9, 1, 0, 0, 0, S_BLOCK, 1, 0);
        cyc(1'b1, 1, 0, 0, 0, S_IDLE, 0, 0);
        cyc(1'b1, 1, 0, 0, 0, S_BACK, 0, 0);
        cyc(1'b1, 0, 1, 0, 0, S_FWD, 0, 0);
        cyc(1'b1, 0, 1, 0, 1, S_HIT, 0, 0);
        run(19, 0, 0, 0, 0, S_HIT, 1, 0);
        cyc(1'b1, 0, 0, 0, 0, S_IDLE, 0, 0);

        // Counter-hit during startup; second hit in stun ignored
        run(2, 0, 0, 1, 0, S_START, 0, 0);
        cyc(1'b1, 0, 0, 1, 1, S_HIT, 0, 0);
        run(4, 0, 0, 0, 0, S_HIT, 1, 0);
        cyc(1'b1, 0, 0, 0, 1, S_HIT, 5, 0);
        run(14, 0, 0, 0, 0, S_HIT, 6, 0);
        cyc(1'b1, 0, 0, 0, 0, S_IDLE, 0, 0);

        // Counter-hit during a directional active phase
        cyc(1'b1, 0, 1, 0, 0, S_FWD, 0, 0);
        run(5, 0, 1, 1, 0, S_START, 0, 1);
        cyc(1'b1, 0, 1, 1, 0, S_ACT, 0, 1);
        cyc(1'b1, 0, 1, 1, 1, S_HIT, 0, 0);
        run(19, 0, 0, 0, 0, S_HIT, 1, 0);
        cyc(1'b1, 0, 0, 0, 0, S_IDLE, 0, 0);

        // Tick every 4th cycle: timings stretch, no change between ticks
        run4(5, 1'b1, S_START, 0, 0);
        run4(2, 1'b1, S_ACT, 0, 0);
        run4(16, 1'b0, S_REC, 0, 0);
        cyc(1'b1, 0, 0, 0, 0, S_IDLE, 0, 0);

        // Asynchronous reset between edges while ACTIVE
        run(5, 0, 0, 1, 0, S_START, 0, 0);
        cyc(1'b1, 0, 0, 1, 0, S_ACT, 0, 0);
        cyc(1'b1, 0, 0, 1, 0, S_IDLE, 0, 0);
        #1 reset = 1'b1;
        cyc(1'b1, 1, 1, 0, 0, S_IDLE, 0, 0);
        reset = 1'b0;
        cyc(1'b1, 1, 1, 0, 0, S_IDLE, 1, 0);
        run(2, 1, 1, 0, 0, S_IDLE, 2, 0);

        // Idle counter saturates at all-ones
        for (int i = 0; i < 70; i++)
            cyc(1'b1, 0, 0, 0, 0, S_IDLE, (i + 4 > 63) ? 63 : i + 4, 0);

        frame_tick = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left in scoreboard, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
